// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: shares the single register-file write port between the
// pipeline writeback stage (primary) and the mult/div unit (secondary).
// The winning request is registered and presented to the register file one
// cycle after acceptance. A starvation counter guarantees the secondary a
// forced grant after STARVE_LIMIT consecutive refusals. Writes to register 0
// complete their handshake but never raise the write enable.
module reg_wr_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4    // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_valid,
  input  logic [4:0]            p_addr,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  p_ready,
  input  logic                  m_valid,
  input  logic [4:0]            m_addr,
  input  logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_ready,
  output logic                  wr_en,
  output logic [4:0]            wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_src
);

  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  // Saturating increment of the starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == LIMIT) begin
      return LIMIT;
    end
    return v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [4:0]            wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_src_q, wr_src_d;

  logic force_m;
  logic grant_p;
  logic grant_m;

  // Arbitration: pipeline wins by default; a saturated starvation counter
  // hands the port to mult/div for one cycle. Readies never look at their
  // own valid, so grant_p and grant_m are mutually exclusive.
  always_comb begin
    force_m = (starve_cnt_q == LIMIT);
    p_ready = !(force_m && m_valid);
    m_ready = !p_valid || force_m;
    grant_p = p_valid && p_ready;
    grant_m = m_valid && m_ready;
  end

  // Next-state: starvation counter and the registered write command.
  // Without a grant only the enable drops; address/data/source hold.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_src_d     = wr_src_q;

    if (m_valid && !grant_m) begin
      starve_cnt_d = sat_inc(starve_cnt_q);
    end else begin
      starve_cnt_d = '0;
    end

    if (grant_p) begin
      wr_addr_d = p_addr;
      wr_data_d = p_data;
      wr_src_d  = 1'b0;
      wr_en_d   = (p_addr != 5'd0);
    end else if (grant_m) begin
      wr_addr_d = m_addr;
      wr_data_d = m_data;
      wr_src_d  = 1'b1;
      wr_en_d   = (m_addr != 5'd0);
    end
  end

  // State registers; reset drops any pending write without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 5'd0;
      wr_data_q    <= '0;
      wr_src_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_src_q     <= wr_src_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: expected write-port contents are pushed
// to a scoreboard when a request is driven and popped after the clock edge.
module tb_reg_wr_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          p_valid, m_valid;
  logic [4:0]    p_addr, m_addr;
  logic [DW-1:0] p_data, m_data;
  logic          p_ready, m_ready;
  logic          wr_en, wr_src;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;

  typedef struct packed {
    logic          en;
    logic [4:0]    addr;
    logic [DW-1:0] data;
    logic          src;
  } wr_t;

  wr_t           sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [4:0]    h_addr = 5'd0;
  logic [DW-1:0] h_data = '0;
  logic          h_src  = 1'b0;

  reg_wr_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_ready(p_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check readies, model the grant, then check
  // the registered write port and starvation counter after the next posedge.
  task automatic step(input string tag,
                      input logic pv, input logic [4:0] pa, input logic [DW-1:0] pd,
                      input logic mv, input logic [4:0] ma, input logic [DW-1:0] md,
                      input logic epr, input logic emr, input int ecnt);
    wr_t e;
    wr_t got;
    @(negedge clk);
    p_valid = pv; p_addr = pa; p_data = pd;
    m_valid = mv; m_addr = ma; m_data = md;
    #1;
    chk({tag, ".p_ready"}, 32'(p_ready), 32'(epr));
    chk({tag, ".m_ready"}, 32'(m_ready), 32'(emr));
    e.en = 1'b0;
    if (pv && epr) begin
      h_addr = pa; h_data = pd; h_src = 1'b0; e.en = (pa != 5'd0);
    end else if (mv && emr) begin
      h_addr = ma; h_data = md; h_src = 1'b1; e.en = (ma != 5'd0);
    end
    e.addr = h_addr; e.data = h_data; e.src = h_src;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk({tag, ".wr_en"},   32'(wr_en),   32'(got.en));
      chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(got.addr));
      chk({tag, ".wr_data"}, wr_data,      got.data);
      chk({tag, ".wr_src"},  32'(wr_src),  32'(got.src));
    end
    chk({tag, ".starve_cnt"}, 32'(dut.starve_cnt_q), 32'(ecnt));
  endtask

  initial begin
    rst = 1'b1;
    p_valid = 1'b0; p_addr = 5'd0; p_data = '0;
    m_valid = 1'b0; m_addr = 5'd0; m_data = '0;
    #2;
    chk("rst.wr_en",   32'(wr_en),   32'd0);
    chk("rst.wr_addr", 32'(wr_addr), 32'd0);
    chk("rst.wr_data", wr_data,      32'd0);
    chk("rst.wr_src",  32'(wr_src),  32'd0);
    chk("rst.cnt",     32'(dut.starve_cnt_q), 32'd0);
    chk("rst.p_ready", 32'(p_ready), 32'd1);
    chk("rst.m_ready", 32'(m_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Pipeline only
    step("p_only", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 0);
    // Contention, default priority
    step("contend", 1'b1, 5'd3, 32'h00000033, 1'b1, 5'd7, 32'h77777777, 1'b1, 1'b0, 1);
    step("idle0", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 0);

    // Starvation: four refusals, then a forced secondary grant
    for (int i = 0; i < 4; i++) begin
      step($sformatf("starve%0d", i), 1'b1, 5'(10 + i), 32'(i + 100),
           1'b1, 5'd9, 32'h12345678, 1'b1, 1'b0, i + 1);
    end
    step("forced", 1'b1, 5'd14, 32'h0000EEEE, 1'b1, 5'd9, 32'h12345678, 1'b0, 1'b1, 0);
    step("p_after", 1'b1, 5'd14, 32'h0000EEEE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 0);

    // Zero register: handshake completes, no write
    step("zero_reg", 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h00000055, 1'b1, 1'b1, 0);

    // Idle hold
    step("wr12", 1'b1, 5'd12, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("hold%0d", i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 0);
    end

    // Back-to-back secondary writes
    step("m_b2b0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h20202020, 1'b1, 1'b1, 0);
    step("m_b2b1", 1'b0, 5'd0, 32'h0, 1'b1, 5'd21, 32'h21212121, 1'b1, 1'b1, 0);

    // Reset mid-operation drops the pending write immediately
    step("pre_rst", 1'b1, 5'd12, 32'hCAFEF00D, 1'b1, 5'd6, 32'h66666666, 1'b1, 1'b0, 1);
    p_valid = 1'b0; m_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst.wr_en",   32'(wr_en),   32'd0);
    chk("mid_rst.wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst.wr_data", wr_data,      32'd0);
    chk("mid_rst.wr_src",  32'(wr_src),  32'd0);
    chk("mid_rst.cnt",     32'(dut.starve_cnt_q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    h_addr = 5'd0; h_data = '0; h_src = 1'b0;

    step("post_rst", 1'b1, 5'd1, 32'h11111111, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Shares the single write port of the 32x32 register file between two writers: the pipeline writeback stage (primary) and the multi-cycle mult/div unit (secondary). Requests use valid/ready handshakes; the granted request is registered and driven onto the register-file write port one cycle later. A starvation counter forces a secondary grant after a bounded wait, and writes to register 0 are accepted but suppressed.

## Interface
- DATA_WIDTH, 32, width of write data
- STARVE_LIMIT, 4, consecutive cycles the secondary may be refused before a forced grant; legal range 1..15
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- p_valid  in  1  pipeline write request
- p_addr  in  5  pipeline destination register
- p_data  in  DATA_WIDTH  pipeline write data
- p_ready  out  1  pipeline request accepted this cycle; low means the pipeline stalls writeback
- m_valid  in  1  mult/div write request
- m_addr  in  5  mult/div destination register
- m_data  in  DATA_WIDTH  mult/div write data
- m_ready  out  1  mult/div request accepted this cycle
- wr_en  out  1  register-file write enable
- wr_addr  out  5  register-file write address
- wr_data  out  DATA_WIDTH  register-file write data
- wr_src  out  1  source of the current write: 0 pipeline, 1 mult/div

## Operation
- Counter starve_cnt, width enough for STARVE_LIMIT, reset 0. force = (starve_cnt == STARVE_LIMIT).
- Combinational arbitration, same cycle:
  - p_ready = !(force && m_valid)
  - m_ready = !p_valid || force
  - grant_p = p_valid && p_ready; grant_m = m_valid && m_ready; never both high.
- p_ready and m_ready do not depend on their own valid; a requester holds valid, addr and data stable until it sees ready.
- starve_cnt update:
  - m_valid && !grant_m: increment, saturate at STARVE_LIMIT
  - grant_m or !m_valid: clear to 0
- Output register update:
  - grant_p: wr_addr<=p_addr, wr_data<=p_data, wr_src<=0, wr_en<=(p_addr!=0)
  - grant_m: wr_addr<=m_addr, wr_data<=m_data, wr_src<=1, wr_en<=(m_addr!=0)
  - no grant: wr_en<=0; wr_addr, wr_data, wr_src hold
- Address 0: the handshake completes normally (ready high, request consumed, starve_cnt clears on grant_m), but wr_en stays 0.
- Both requesters targeting the same register in one cycle: only the granted one is written that cycle. The other is written in a later cycle, so the later write wins. Ordering is not the arbiter's concern.

## Timing
- Reset values: wr_en 0, wr_addr 0, wr_data 0, wr_src 0, starve_cnt 0. p_ready=1 and m_ready=1 follow combinationally from the inputs.
- Latency: request accepted at edge N, so wr_en, wr_addr and wr_data are valid during cycle N+1. The register file writes at edge N+2's preceding edge (the edge ending cycle N+1).
- Throughput: one write per cycle, sustained. Back-to-back grants from either source are allowed.
- Secondary worst-case wait with p_valid held high: STARVE_LIMIT refused cycles, then grant in the next cycle. The pipeline is stalled (p_ready=0) for exactly that one cycle.
- After a forced grant starve_cnt is 0, so the pipeline keeps priority for at least the next STARVE_LIMIT cycles.
- Reset asserted mid-operation:
  - All outputs and starve_cnt clear immediately, asynchronously.
  - A write registered but not yet performed is dropped (wr_en falls without waiting for a clock edge).
  - Requesters re-present after reset deasserts.

## Test plan
- Reset: assert rst between edges with wr_en=1 -> wr_en, wr_addr, wr_data, wr_src read 0 before the next edge; starve_cnt=0.
- Pipeline only: p_valid=1, p_addr=5, p_data=0xDEADBEEF for one cycle -> p_ready=1; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, wr_src=0.
- Contention, default priority: p_valid=1 (addr 3) and m_valid=1 (addr 7) for one cycle -> p_ready=1, m_ready=0; next cycle wr_addr=3, wr_src=0; starve_cnt=1.
- Starvation, STARVE_LIMIT=4: p_valid and m_valid held high (m_addr 9, m_data 0x12345678) -> m refused 4 cycles. Cycle 5: m_ready=1, p_ready=0. Following cycle: wr_addr=9, wr_data=0x12345678, wr_src=1; starve_cnt returns to 0 and the pipeline is granted next.
- Zero register: m_valid=1, m_addr=0, p_valid=0 -> m_ready=1; next cycle wr_en=0, wr_src=1; starve_cnt=0.
- Idle hold: after writing addr 12, data 0xA5A5A5A5, drop all valids for 3 cycles -> wr_en=0, while wr_addr=12 and wr_data=0xA5A5A5A5 hold.
